// File: rtl/h_next_tiled.sv
// h_next_tiled: per-lane fp16 h_next = dBx + dAh through fixed-latency adders,
// with a credit-checked output FIFO absorbing downstream backpressure.

module fp16_add_wrapper #(
  parameter int unsigned LAT = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] sum
);

  // IEEE fp16 add, round-to-nearest-even, canonical quiet NaN 0x7E00.
  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] big_w, small_w, r;
    logic [10:0] mb, ms;
    logic [24:0] wide;
    logic [13:0] big, al;
    logic [14:0] s;
    logic [11:0] mr;
    logic        up;
    int          e, d;
    r = '0;
    if ((x[14:10] == 5'h1f && x[9:0] != '0) || (y[14:10] == 5'h1f && y[9:0] != '0)) begin
      r = 16'h7e00;
    end else if (x[14:10] == 5'h1f && y[14:10] == 5'h1f) begin
      r = (x[15] == y[15]) ? x : 16'h7e00;
    end else if (x[14:10] == 5'h1f) begin
      r = x;
    end else if (y[14:10] == 5'h1f) begin
      r = y;
    end else begin
      if (x[14:0] >= y[14:0]) begin
        big_w = x;
        small_w = y;
      end else begin
        big_w = y;
        small_w = x;
      end
      mb = {big_w[14:10] != 5'd0, big_w[9:0]};
      ms = {small_w[14:10] != 5'd0, small_w[9:0]};
      e  = (big_w[14:10] == 5'd0) ? 1 : int'(big_w[14:10]);
      d  = e - ((small_w[14:10] == 5'd0) ? 1 : int'(small_w[14:10]));
      if (d > 25) d = 25;
      // Aligned operand keeps two guard bits plus a sticky bit.
      wide = {ms, 14'b0} >> d;
      al   = {wide[24:12], |wide[11:0]};
      big  = {mb, 3'b000};
      s = (x[15] == y[15]) ? ({1'b0, big} + {1'b0, al}) : ({1'b0, big} - {1'b0, al});
      if (s == '0) begin
        r = {x[15] & y[15], 15'b0};
      end else begin
        if (s[14]) begin
          s = {1'b0, s[14:2], s[1] | s[0]};
          e++;
        end
        for (int unsigned i = 0; i < 13; i++) begin
          if (!s[13] && e > 1) begin
            s = s << 1;
            e--;
          end
        end
        up = s[2] & (s[1] | s[0] | s[3]);
        mr = {1'b0, s[13:3]} + 12'(up);
        if (mr[11]) begin
          mr = mr >> 1;
          e++;
        end
        if (e >= 31) r = {big_w[15], 15'h7c00};
        else         r = {big_w[15], mr[10] ? 5'(e) : 5'd0, mr[9:0]};
      end
    end
    return r;
  endfunction

  logic [LAT-1:0] vpipe;
  logic [15:0]    dpipe [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
      for (int unsigned i = 0; i < LAT; i++) dpipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[LAT-2:0], valid_in};
      dpipe[0] <= fp16_add(a, b);
      for (int unsigned i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end

  assign valid_out = vpipe[LAT-1];
  assign sum       = dpipe[LAT-1];

endmodule

module h_next_tiled #(
  parameter int unsigned DW         = 16,
  parameter int unsigned N_TILE     = 16,
  parameter int unsigned N_TOTAL    = 128,
  parameter int unsigned ADD_LAT    = 11,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     mode_i,
  input  logic [N_TILE*DW-1:0]     dBx_i,
  input  logic [N_TILE*DW-1:0]     dAh_i,
  output logic [N_TILE*DW-1:0]     hnext_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [((N_TOTAL/N_TILE) > 1 ? $clog2(N_TOTAL/N_TILE) : 1)-1:0] tile_idx_o,
  output logic                     last_o
);

  localparam int unsigned NT  = N_TOTAL / N_TILE;
  localparam int unsigned TW  = (NT > 1) ? $clog2(NT) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic                 accept, push, pop;
  logic [CW-1:0]        inflight, occ;
  logic [CW:0]          credit_used;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [N_TILE*DW-1:0] mem [FIFO_DEPTH];
  logic [N_TILE*DW-1:0] dah_gated, lane_sum;
  logic [N_TILE-1:0]    lane_valid;
  logic                 unused_lane_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dah_gated = mode_i ? '0 : dAh_i;

  for (genvar n = 0; n < N_TILE; n++) begin : g_lane
    fp16_add_wrapper #(.LAT(ADD_LAT)) u_add (
      .clk      (clk),
      .rstn     (rstn),
      .valid_in (accept),
      .a        (dBx_i[n*DW +: DW]),
      .b        (dah_gated[n*DW +: DW]),
      .valid_out(lane_valid[n]),
      .sum      (lane_sum[n*DW +: DW])
    );
  end

  // All lanes share one valid timeline; lane 0 drives the push.
  assign unused_lane_valid = ^lane_valid;
  assign push              = lane_valid[0];

  assign credit_used = {1'b0, inflight} + {1'b0, occ};
  assign ready_o     = credit_used < CW1'(FIFO_DEPTH);
  assign accept      = valid_i && ready_o;
  assign valid_o     = (occ != '0);
  assign pop         = valid_o && ready_i;
  assign hnext_o     = mem[rd_ptr];
  assign last_o      = valid_o && (tile_idx_o == TW'(NT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      occ        <= '0;
      tile_idx_o <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= lane_sum;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        tile_idx_o <= (tile_idx_o == TW'(NT - 1)) ? '0 : tile_idx_o + TW'(1);
      end
      inflight <= inflight + CW'(accept) - CW'(push);
      occ      <= occ + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_h_next_tiled.sv
// Directed bench for h_next_tiled: latency, pass mode, streaming tiles,
// backpressure, random flow control and mid-operation reset.

module tb_h_next_tiled;

  localparam int unsigned DW = 16, NL = 16, NTOT = 64, LAT = 11, DEPTH = 16, NT = 4;
  localparam int unsigned VW = NL * DW;

  logic          clk = 1'b0;
  logic          rstn, valid_i, ready_o, mode_i, valid_o, ready_i, last_o;
  logic [VW-1:0] dBx_i, dAh_i, hnext_o;
  logic [1:0]    tile_idx_o;

  always #5 clk = ~clk;

  h_next_tiled #(
    .DW(DW), .N_TILE(NL), .N_TOTAL(NTOT), .ADD_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i),
    .dBx_i(dBx_i), .dAh_i(dAh_i), .hnext_o(hnext_o), .valid_o(valid_o),
    .ready_i(ready_i), .tile_idx_o(tile_idx_o), .last_o(last_o)
  );

  int            n_cmp = 0, n_bad = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_cur, hold;
  int            exp_tile = 0;
  bit            acc, have_hold;
  int            lat, accepts, sent, cyc;
  int unsigned   bx[NL], ah[NL];

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Exact fp16 encoding of a small non-negative integer (< 2048).
  function automatic logic [15:0] i2h(input int unsigned v);
    int unsigned p = 0;
    if (v == 0) return 16'h0000;
    for (int unsigned i = 0; i < 11; i++) if ((v >> i) != 0) p = i;
    return {1'b0, 5'(15 + p), 10'((v << (10 - p)) & 32'h3ff)};
  endfunction

  task automatic load();
    for (int n = 0; n < NL; n++) begin
      dBx_i[n*DW +: DW]   = i2h(bx[n]);
      dAh_i[n*DW +: DW]   = i2h(ah[n]);
      exp_cur[n*DW +: DW] = i2h(bx[n] + ah[n]);
    end
    mode_i = 1'b0;
  endtask

  // Called at a negedge with inputs set; scores the pop and the accept of this cycle.
  task automatic tick(output bit a);
    a = valid_i && ready_o;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("stray_valid_o", VW'(valid_o), '0);
      end else begin
        chk("hnext_o", hnext_o, exp_q.pop_front());
        chk("tile_idx_o", VW'(tile_idx_o), VW'(exp_tile));
        chk("last_o", VW'(last_o), VW'(exp_tile == NT - 1));
        exp_tile = (exp_tile + 1) % NT;
      end
    end
    if (a) begin
      exp_q.push_back(exp_cur);
      chk("credit_bound", VW'(exp_q.size() <= DEPTH), VW'(1));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    bit a;
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(a);
      k++;
    end
    chk("drain_timeout", VW'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("rst_valid_o", VW'(valid_o), '0);
    chk("rst_ready_o", VW'(ready_o), VW'(1));
    chk("rst_hnext_o", hnext_o, '0);
    chk("rst_tile_idx_o", VW'(tile_idx_o), '0);
    chk("rst_last_o", VW'(last_o), '0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    exp_tile = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b1; mode_i = 1'b0;
    dBx_i = '0; dAh_i = '0; exp_cur = '0; hold = '0;
    do_reset();

    // 1.0 + 2.0 = 3.0 in every lane, latency ADD_LAT+1
    valid_i = 1'b1;
    dBx_i = {NL{16'h3c00}}; dAh_i = {NL{16'h4000}}; exp_cur = {NL{16'h4200}};
    tick(acc);
    chk("basic_accept", VW'(acc), VW'(1));
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 40) begin
      tick(acc);
      lat++;
    end
    chk("basic_latency", VW'(lat + 1), VW'(LAT + 1));
    drain(5);

    // pass mode ignores an infinite dAh; add mode then yields inf
    valid_i = 1'b1; mode_i = 1'b1;
    dBx_i = {NL{16'h3c00}}; dAh_i = {NL{16'h7c00}}; exp_cur = {NL{16'h3c00}};
    tick(acc);
    mode_i = 1'b0; exp_cur = {NL{16'h7c00}};
    tick(acc);
    valid_i = 1'b0;
    drain(40);

    // streaming: 12 back-to-back beats, tiles 0..3 repeated
    do_reset();
    ready_i = 1'b1;
    for (int b = 0; b < 12; b++) begin
      for (int n = 0; n < NL; n++) begin
        bx[n] = b * 16 + n + 1;
        ah[n] = 3 * n + b;
      end
      load();
      valid_i = 1'b1;
      chk("stream_ready_o", VW'(ready_o), VW'(1));
      tick(acc);
    end
    valid_i = 1'b0;
    drain(40);

    // backpressure: 30 cycles of valid with ready_i low
    do_reset();
    ready_i = 1'b0; accepts = 0; have_hold = 1'b0;
    for (int c = 0; c < 30; c++) begin
      for (int n = 0; n < NL; n++) begin
        bx[n] = 100 + accepts * 7 + n;
        ah[n] = 2 * n + accepts;
      end
      load();
      valid_i = 1'b1;
      if (accepts == DEPTH) chk("bp_ready_low", VW'(ready_o), '0);
      if (valid_o) begin
        if (have_hold) chk("bp_head_stable", hnext_o, hold);
        hold = hnext_o;
        have_hold = 1'b1;
      end
      tick(acc);
      if (acc) accepts++;
    end
    chk("bp_accepts", VW'(accepts), VW'(DEPTH));
    valid_i = 1'b0; ready_i = 1'b1;
    tick(acc);
    chk("bp_ready_rise", VW'(ready_o), VW'(1));
    drain(40);

    // random valid/ready, 1000 beats
    sent = 0; cyc = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      ready_i = 1'($urandom_range(0, 1));
      if (!valid_i && sent < 1000 && $urandom_range(0, 1) == 1) begin
        for (int n = 0; n < NL; n++) begin
          bx[n] = $urandom_range(0, 1023);
          ah[n] = $urandom_range(0, 1023);
        end
        load();
        valid_i = 1'b1;
      end
      tick(acc);
      if (acc) begin
        sent++;
        valid_i = 1'b0;
      end
      cyc++;
    end
    chk("rand_sent", VW'(sent), VW'(1000));
    chk("rand_left", VW'(exp_q.size()), '0);
    valid_i = 1'b0; ready_i = 1'b1;

    // reset with 5 beats in flight and 3 in the FIFO
    do_reset();
    ready_i = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int n = 0; n < NL; n++) begin
        bx[n] = n + 2 * b + 1;
        ah[n] = b;
      end
      load();
      valid_i = 1'b1;
      tick(acc);
    end
    valid_i = 1'b0;
    repeat (6) tick(acc);
    chk("pre_reset_valid_o", VW'(valid_o), VW'(1));
    do_reset();
    ready_i = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      chk("no_stale_valid_o", VW'(valid_o), '0);
      tick(acc);
    end
    for (int n = 0; n < NL; n++) begin
      bx[n] = 500 + n;
      ah[n] = 7;
    end
    load();
    valid_i = 1'b1;
    tick(acc);
    valid_i = 1'b0;
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/h_next_tiled.md
# h_next_tiled

Tiled, flow-controlled successor to the 16-lane state-update adder in the SSM datapath. It computes h_next = dBx + dAh per lane over N_TILE fp16 lanes per beat, using one fp16_add_wrapper per lane. It folds an N_TOTAL-element state vector into N_TOTAL/N_TILE consecutive beats and supports a per-beat "initial state" mode, in which h_prev = 0. Because the adder pipeline cannot stall, a credit-checked output FIFO absorbs backpressure. The block sits between the dA·h multiplier and the y-projection / state write-back stage.

## Interface
- DW, 16, element width (fp16)
- N_TILE, 16, lanes per beat
- N_TOTAL, 128, state elements per vector; must be a multiple of N_TILE
- ADD_LAT, 11, fixed latency of fp16_add_wrapper (valid_in to valid_out)
- FIFO_DEPTH, 16, output FIFO entries; must be ≥ ADD_LAT+2

Ports:
- clk  in  1  clock, single domain
- rstn  in  1  asynchronous active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- mode_i  in  1  0: hnext = dBx + dAh; 1: hnext = dBx (dAh ignored)
- dBx_i  in  N_TILE*DW  dB·x lanes, lane n at [n*DW +: DW]
- dAh_i  in  N_TILE*DW  dA·h lanes, same packing
- hnext_o  out  N_TILE*DW  result lanes, same packing
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream ready; pop on valid_o && ready_i
- tile_idx_o  out  clog2(N_TOTAL/N_TILE) (min 1)  tile index of the current output beat
- last_o  out  1  high when tile_idx_o == N_TOTAL/N_TILE−1 and valid_o is high

## Operation
- Accept: on valid_i && ready_o, every lane adder launches in that cycle.
  - Lane n a-input = dBx_i lane n.
  - Lane n b-input = mode_i ? 16'h0000 : dAh_i lane n.
  - The pass mode goes through the adder, so latency is identical in both modes.
- Adder results are pushed into the FIFO when lane 0's valid_out rises. All lanes share valid timing; lane 0's valid is authoritative.
- Credit: inflight counts beats launched but not yet pushed; occ counts FIFO entries.
  - ready_o = (inflight + occ) < FIFO_DEPTH, combinational from registered counters.
  - Overflow is therefore impossible.
- Counter updates:
  - Accept: inflight+1.
  - Push: inflight−1, occ+1.
  - Pop: occ−1.
  - Any combination of accept, push and pop in the same cycle nets correctly.
- Output:
  - valid_o = (occ != 0).
  - hnext_o shows the FIFO head.
  - The FIFO head is held stable while valid_o && !ready_i.
- Tile counter: advances on each pop and wraps from N_TOTAL/N_TILE−1 to 0. Ordering is strictly FIFO, so output order equals acceptance order.
- fp16 semantics (rounding, NaN, inf, subnormals) are exactly those of fp16_add_wrapper. The block adds no arithmetic of its own.

## Timing
- Reset values (asynchronous, all registers):
  - valid_o = 0, last_o = 0, tile_idx_o = 0, hnext_o = 0.
  - inflight = 0, occ = 0; ready_o = 1 out of reset.
  - FIFO pointers = 0.
- Reset mid-operation: in-flight beats and FIFO contents are discarded, and the tile counter returns to 0. The adder valid pipeline must also clear; results from beats accepted before reset never appear.
- Latency: a beat accepted in cycle t with the FIFO empty gives valid_o high in cycle t+ADD_LAT+1.
- Throughput: one beat per cycle sustained while ready_i = 1.
- Backpressure:
  - With ready_i = 0, at most FIFO_DEPTH beats are accepted.
  - ready_o falls in the cycle after the FIFO_DEPTH-th accept.
  - ready_o rises the cycle after the first pop frees a credit.
- FIFO wrap: read and write pointers wrap modulo FIFO_DEPTH. FIFO_DEPTH need not be a power of two.
- Simultaneous push into an empty FIFO plus a pop is not possible in the same cycle; the entry becomes visible the next cycle.
- Full FIFO with a simultaneous pop and push (possible only via credit) must retain both entries correctly.

## Test plan
- Basic add, mode_i = 0: all lanes dBx = 0x3C00, dAh = 0x4000 → all lanes 0x4200, valid_o exactly ADD_LAT+1 cycles after accept, tile_idx_o = 0.
- Pass mode: mode_i = 1, dBx = 0x3C00, dAh = 0x7C00 (inf) → all lanes 0x3C00; then mode_i = 0 with the same data → 0x7C00.
- Streaming with N_TOTAL = 64, N_TILE = 16, ready_i = 1, 12 back-to-back beats with per-lane distinct values:
  - ready_o stays 1 throughout.
  - tile_idx_o sequence is 0,1,2,3 repeated.
  - last_o is high on beats 4, 8 and 12.
  - Results match a reference model.
- Backpressure: ready_i = 0, drive valid_i for 30 cycles → exactly 16 accepts, then ready_o = 0. Release ready_i → 16 results in order, none lost or duplicated, hnext_o stable while stalled.
- Random ready_i (50%) and valid_i, 1000 beats → scoreboard match, credit counters never exceed FIFO_DEPTH.
- Reset asserted with 5 beats in flight and 3 in the FIFO:
  - Outputs immediately at reset values.
  - After release, no stale valid_o within ADD_LAT+2 cycles.
  - Next beat returns tile_idx_o = 0.
